// File: rtl/s38584_sync_word_tx_pkg.sv
// Shared definitions for the s38584 sync-word transmitter and the detector-side check.
// Keeping the pattern in one place guarantees both ends agree on it.
package s38584_sync_pkg;

  localparam int WORD_W = 7;
  // Bit order {b255,b232,b225,b269,b262,b239,b246}
  localparam logic [WORD_W-1:0] SYNC_PAT = 7'b1001100;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

  function automatic logic [WORD_W-1:0] sync_word(input logic phase);
    return phase ? ~SYNC_PAT : SYNC_PAT;
  endfunction

endpackage

// File: rtl/s38584_sync_word_tx_if.sv
// Payload-in and transmit-out handshake bundle for the sync-word transmitter.
// The slave modport is the transmitter's view; master is the surrounding environment.
interface s38584_sync_word_tx_if;
  import s38584_sync_pkg::*;

  logic [WORD_W-1:0] in_word;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] tx_word;
  logic              tx_phase;
  logic              tx_en;
  logic              tx_valid;
  logic              tx_esc;
  logic              tx_ready;

  modport master (
    output in_word, in_valid, tx_ready,
    input  in_ready, tx_word, tx_phase, tx_en, tx_valid, tx_esc
  );

  modport slave (
    input  in_word, in_valid, tx_ready,
    output in_ready, tx_word, tx_phase, tx_en, tx_valid, tx_esc
  );

endinterface

// File: rtl/s38584_sync_word_tx_outreg.sv
// Output register for the sync-word transmitter: holds word/phase/esc while stalled,
// reloads on 'load', and drops valid on 'clear' when nothing new arrives.
module s38584_tx_outreg
  import s38584_sync_pkg::*;
(
  input  logic              CK,
  input  logic              RST,
  input  logic              load,
  input  logic              clear,
  input  logic [WORD_W-1:0] d_word,
  input  logic              d_phase,
  input  logic              d_esc,
  output logic [WORD_W-1:0] q_word,
  output logic              q_phase,
  output logic              q_esc,
  output logic              q_valid
);

  // load has priority so a draining word can be replaced in the same cycle
  always_ff @(posedge CK) begin
    if (RST) begin
      q_word  <= '0;
      q_phase <= 1'b0;
      q_esc   <= 1'b0;
      q_valid <= 1'b0;
    end else if (load) begin
      q_word  <= d_word;
      q_phase <= d_phase;
      q_esc   <= d_esc;
      q_valid <= 1'b1;
    end else if (clear) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/s38584_sync_word_tx.sv
// Framed burst transmitter: SYNC_CNT alternating-phase sync words, LEN payload words
// (escaped when they collide with a sync pattern), then GAP_CYC idle cycles with tx_en held.
module s38584_sync_word_tx
  import s38584_sync_pkg::*;
#(
  parameter int SYNC_CNT = 4,
  parameter int LEN_W    = 8,
  parameter int GAP_CYC  = 3
) (
  input  logic                   CK,
  input  logic                   RST,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  s38584_sync_word_tx_if.slave   bus,
  output logic                   busy
);

  localparam int     SYNC_W = $clog2(SYNC_CNT + 1);
  localparam int     GAP_W  = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam state_t END_ST = (GAP_CYC == 0) ? IDLE : GAP;

  state_t            state, state_n;
  logic [SYNC_W-1:0] sync_cnt, sync_n;
  logic [LEN_W-1:0]  len_cnt, len_n;
  logic [GAP_W-1:0]  gap_cnt, gap_n;
  logic              phase, phase_n;
  logic              tx_en_q;
  logic              ld, clr, in_rdy;
  logic [WORD_W-1:0] d_word;
  logic              d_phase, d_esc;
  logic              tx_acc, is_sync;

  assign tx_acc      = bus.tx_valid && bus.tx_ready;
  assign is_sync     = (bus.in_word == SYNC_PAT) || (bus.in_word == ~SYNC_PAT);
  assign bus.in_ready = in_rdy;
  assign bus.tx_en   = tx_en_q;
  assign busy        = (state != IDLE);

  s38584_tx_outreg u_outreg (
    .CK      (CK),
    .RST     (RST),
    .load    (ld),
    .clear   (clr),
    .d_word  (d_word),
    .d_phase (d_phase),
    .d_esc   (d_esc),
    .q_word  (bus.tx_word),
    .q_phase (bus.tx_phase),
    .q_esc   (bus.tx_esc),
    .q_valid (bus.tx_valid)
  );

  // tx_en follows the next state so it drops exactly when the frame returns to IDLE
  always_ff @(posedge CK) begin
    if (RST) begin
      state    <= IDLE;
      sync_cnt <= '0;
      len_cnt  <= '0;
      gap_cnt  <= '0;
      phase    <= 1'b0;
      tx_en_q  <= 1'b0;
    end else begin
      state    <= state_n;
      sync_cnt <= sync_n;
      len_cnt  <= len_n;
      gap_cnt  <= gap_n;
      phase    <= phase_n;
      tx_en_q  <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    sync_n  = sync_cnt;
    len_n   = len_cnt;
    gap_n   = gap_cnt;
    phase_n = phase;
    ld      = 1'b0;
    clr     = 1'b0;
    in_rdy  = 1'b0;
    d_word  = sync_word(phase);
    d_phase = phase;
    d_esc   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SYNC;
          len_n   = len;
          sync_n  = SYNC_W'(SYNC_CNT);
          phase_n = 1'b0;
          ld      = 1'b1;
          d_word  = sync_word(1'b0);
          d_phase = 1'b0;
        end
      end

      SYNC: begin
        if (tx_acc) begin
          sync_n  = sync_cnt - 1'b1;
          phase_n = ~phase;
          if (sync_cnt == SYNC_W'(1)) begin
            clr = 1'b1;
            if (len_cnt == '0) begin
              state_n = END_ST;
              gap_n   = GAP_W'(GAP_CYC);
            end else begin
              state_n = DATA;
            end
          end else begin
            ld      = 1'b1;
            d_word  = sync_word(~phase);
            d_phase = ~phase;
          end
        end
      end

      DATA: begin
        // Never pull a payload word beyond the frame length, even while draining the last one
        in_rdy = bus.tx_valid ? (bus.tx_ready && (len_cnt != LEN_W'(1))) : 1'b1;
        if (tx_acc) begin
          len_n = len_cnt - 1'b1;
          if (len_cnt == LEN_W'(1)) begin
            state_n = END_ST;
            gap_n   = GAP_W'(GAP_CYC);
          end
        end
        if (bus.in_valid && in_rdy) begin
          ld      = 1'b1;
          d_word  = is_sync ? (bus.in_word ^ WORD_W'(1)) : bus.in_word;
          d_phase = bus.tx_phase;
          d_esc   = is_sync;
        end else if (tx_acc) begin
          clr = 1'b1;
        end
      end

      GAP: begin
        gap_n = gap_cnt - 1'b1;
        if (gap_cnt <= GAP_W'(1)) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
